// File: rtl/via_interface_adapter.sv
// Parallel I/O and timer peripheral for the 6502 bus window 0x0800-0x080F.
// Two 8-bit ports with per-bit direction, a 16-bit free-running down-counter
// and a polled interrupt-flag register. The bus has no strobe: every clock edge
// with chip_en high writes data_in into the selected writable register.
module via_interface_adapter (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_a_in,
    output logic [7:0] port_a_out,
    input  logic [7:0] port_b_in,
    output logic [7:0] port_b_out,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic [3:0] register_select,
    input  logic       chip_en
);

    localparam logic [3:0] AddrIrb    = 4'h0;
    localparam logic [3:0] AddrIra    = 4'h1;
    localparam logic [3:0] AddrDdrb   = 4'h2;
    localparam logic [3:0] AddrDdra   = 4'h3;
    localparam logic [3:0] AddrOrb    = 4'h4;
    localparam logic [3:0] AddrOra    = 4'h5;
    localparam logic [3:0] AddrT1LLo  = 4'h6;
    localparam logic [3:0] AddrT1LHi  = 4'h7;
    localparam logic [3:0] AddrT1CLo  = 4'h8;
    localparam logic [3:0] AddrT1CHi  = 4'h9;
    localparam logic [3:0] AddrIfr    = 4'hA;
    localparam logic [3:0] AddrIfrClr = 4'hB;
    localparam logic [3:0] AddrIer    = 4'hC;

    logic [7:0]  ddra_q, ddra_d;
    logic [7:0]  ddrb_q, ddrb_d;
    logic [7:0]  ora_q, ora_d;
    logic [7:0]  orb_q, orb_d;
    logic [7:0]  latch_lo_q, latch_lo_d;
    logic [7:0]  latch_hi_q, latch_hi_d;
    logic [15:0] cnt_q, cnt_d;
    logic        run_q, run_d;
    logic        ifr_q, ifr_d;
    logic        ier_q, ier_d;

    logic wr_ddra, wr_ddrb, wr_ora, wr_orb;
    logic wr_lat_lo, wr_lat_hi, wr_ifr_clr, wr_ier;
    logic timeout;
    logic [7:0] ira, irb;
    logic [7:0] rdata;

    assign wr_ddrb    = chip_en && (register_select == AddrDdrb);
    assign wr_ddra    = chip_en && (register_select == AddrDdra);
    assign wr_orb     = chip_en && (register_select == AddrOrb);
    assign wr_ora     = chip_en && (register_select == AddrOra);
    assign wr_lat_lo  = chip_en && (register_select == AddrT1LLo);
    assign wr_lat_hi  = chip_en && (register_select == AddrT1LHi);
    assign wr_ifr_clr = chip_en && (register_select == AddrIfrClr);
    assign wr_ier     = chip_en && (register_select == AddrIer);

    // Counter sitting at zero while running is the expiry event.
    assign timeout = run_q && (cnt_q == 16'h0000);

    // Register-file next state: plain overwrite on a selected edge.
    always_comb begin
        ddra_d     = wr_ddra   ? data_in : ddra_q;
        ddrb_d     = wr_ddrb   ? data_in : ddrb_q;
        ora_d      = wr_ora    ? data_in : ora_q;
        orb_d      = wr_orb    ? data_in : orb_q;
        latch_lo_d = wr_lat_lo ? data_in : latch_lo_q;
        latch_hi_d = wr_lat_hi ? data_in : latch_hi_q;
        ier_d      = wr_ier    ? data_in[0] : ier_q;
    end

    // Timer and flag next state; a latch-high write beats the reload, set beats clear.
    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (wr_lat_hi) begin
            cnt_d = {data_in, latch_lo_q};
            run_d = 1'b1;
        end else if (run_q) begin
            cnt_d = timeout ? {latch_hi_q, latch_lo_q} : (cnt_q - 16'd1);
        end

        ifr_d = ifr_q;
        if (timeout) begin
            ifr_d = 1'b1;
        end else if (wr_ifr_clr && data_in[0]) begin
            ifr_d = 1'b0;
        end
    end

    // State update with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            ddra_q     <= 8'h00;
            ddrb_q     <= 8'h00;
            ora_q      <= 8'h00;
            orb_q      <= 8'h00;
            latch_lo_q <= 8'h00;
            latch_hi_q <= 8'h00;
            cnt_q      <= 16'h0000;
            run_q      <= 1'b0;
            ifr_q      <= 1'b0;
            ier_q      <= 1'b0;
        end else begin
            ddra_q     <= ddra_d;
            ddrb_q     <= ddrb_d;
            ora_q      <= ora_d;
            orb_q      <= orb_d;
            latch_lo_q <= latch_lo_d;
            latch_hi_q <= latch_hi_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            ifr_q      <= ifr_d;
            ier_q      <= ier_d;
        end
    end

    // Output pins drive only the bits configured as outputs.
    assign port_a_out = ora_q & ddra_q;
    assign port_b_out = orb_q & ddrb_q;

    // Input read-back merges driven bits with pin state on input bits.
    assign ira = (ora_q & ddra_q) | (port_a_in & ~ddra_q);
    assign irb = (orb_q & ddrb_q) | (port_b_in & ~ddrb_q);

    // Combinational read mux; unmapped and write-only addresses read zero.
    always_comb begin
        rdata = 8'h00;
        case (register_select)
            AddrIrb:   rdata = irb;
            AddrIra:   rdata = ira;
            AddrDdrb:  rdata = ddrb_q;
            AddrDdra:  rdata = ddra_q;
            AddrOrb:   rdata = orb_q;
            AddrOra:   rdata = ora_q;
            AddrT1LLo: rdata = latch_lo_q;
            AddrT1LHi: rdata = latch_hi_q;
            AddrT1CLo: rdata = cnt_q[7:0];
            AddrT1CHi: rdata = cnt_q[15:8];
            AddrIfr:   rdata = {ifr_q & ier_q, 6'b000000, ifr_q};
            AddrIer:   rdata = {7'b0000000, ier_q};
            default:   rdata = 8'h00;
        endcase
    end

    assign data_out = chip_en ? rdata : 8'h00;

endmodule

// File: tb/tb_via_interface_adapter.sv
// Bench for via_interface_adapter: directed scenarios with fixed expected values,
// then randomized bus traffic checked every cycle against a behavioural model.
module tb_via_interface_adapter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] port_a_in, port_a_out, port_b_in, port_b_out;
    logic [7:0] data_in, data_out;
    logic [3:0] register_select;
    logic       chip_en;

    int total = 0;
    int bad   = 0;

    via_interface_adapter dut (
        .clk             (clk),
        .reset           (reset),
        .port_a_in       (port_a_in),
        .port_a_out      (port_a_out),
        .port_b_in       (port_b_in),
        .port_b_out      (port_b_out),
        .data_in         (data_in),
        .data_out        (data_out),
        .register_select (register_select),
        .chip_en         (chip_en)
    );

    always #5 clk = ~clk;

    // Behavioural model: a register array indexed by address plus a timer value.
    logic [7:0] m_reg [16];
    int         m_cnt;
    bit         m_run;
    bit         m_ifr;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
        m_cnt = 0;
        m_run = 0;
        m_ifr = 0;
    endtask

    function automatic logic [7:0] model_read();
        logic [7:0] v;
        if (!chip_en) return 8'h00;
        case (register_select)
            4'h0: v = (m_reg[4] & m_reg[2]) | (port_b_in & ~m_reg[2]);
            4'h1: v = (m_reg[5] & m_reg[3]) | (port_a_in & ~m_reg[3]);
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: v = m_reg[register_select];
            4'h8: v = 8'(m_cnt % 256);
            4'h9: v = 8'(m_cnt / 256);
            4'hA: v = (m_ifr ? 8'h01 : 8'h00) | ((m_ifr && m_reg[12][0]) ? 8'h80 : 8'h00);
            4'hC: v = {7'd0, m_reg[12][0]};
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Apply one clock edge's worth of behaviour using the current bus inputs.
    task automatic model_edge();
        bit expired;
        int new_cnt;
        if (reset) begin
            model_reset();
            return;
        end
        expired = m_run && (m_cnt == 0);
        new_cnt = m_cnt;
        if (m_run) new_cnt = expired ? (m_reg[7] * 256 + m_reg[6]) : (m_cnt - 1);
        if (chip_en && register_select == 4'h7) begin
            new_cnt = data_in * 256 + m_reg[6];
            m_run = 1;
        end
        if (expired) m_ifr = 1;
        else if (chip_en && register_select == 4'hB && data_in[0]) m_ifr = 0;
        if (chip_en && (register_select inside {[4'h2:4'h7], 4'hC}))
            m_reg[register_select] = (register_select == 4'hC) ? {7'd0, data_in[0]} : data_in;
        m_cnt = new_cnt;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] sel, input logic [7:0] din);
        chip_en = en;
        register_select = sel;
        data_in = din;
        #1;
    endtask

    // Compare every output against the model, then advance one edge.
    task automatic tick();
        check("mdl_dout", data_out, model_read());
        check("mdl_pa", port_a_out, m_reg[5] & m_reg[3]);
        check("mdl_pb", port_b_out, m_reg[4] & m_reg[2]);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        reset = 1'b0;
        port_a_in = 8'h00;
        port_b_in = 8'hFF;
        model_reset();
        drive(1'b0, 4'h0, 8'h00);
        @(negedge clk);

        // 1: reset, port B reads pulled-in pins
        reset = 1'b1;
        drive(1'b0, 4'h0, 8'h00);
        @(posedge clk);
        model_edge();
        #1;
        reset = 1'b0;
        drive(1'b1, 4'h0, 8'h00);
        check("irb_pullin", data_out, 8'hFF);
        check("rst_pa", port_a_out, 8'h00);
        check("rst_pb", port_b_out, 8'h00);
        tick();

        // 2: port B direction and output
        drive(1'b1, 4'h2, 8'h0F); tick();
        drive(1'b1, 4'h4, 8'hA5); tick();
        port_b_in = 8'hF0;
        drive(1'b1, 4'h0, 8'h00);
        check("pb_out", port_b_out, 8'h05);
        check("irb_mix", data_out, 8'hF5);
        tick();

        // 3: chip enable gating
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'h4, 8'h55);
            check("ce_off_dout", data_out, 8'h00);
            tick();
        end
        drive(1'b1, 4'h0, 8'h00);
        check("ce_off_irb", data_out, 8'hF5);
        check("ce_off_pb", port_b_out, 8'h05);
        tick();

        // 4: timer timeout and reload
        drive(1'b1, 4'h6, 8'h03); tick();
        drive(1'b1, 4'h7, 8'h00); tick();
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, 4'h8, 8'h00);
            check("t1_count", data_out, 8'(i));
            tick();
        end
        drive(1'b1, 4'h8, 8'h00);
        check("t1_reload", data_out, 8'h03);
        drive(1'b1, 4'hA, 8'h00);
        check("ifr_set", data_out, 8'h01);
        tick();
        drive(1'b1, 4'hB, 8'h01); tick();
        drive(1'b1, 4'hA, 8'h00);
        check("ifr_clear", data_out, 8'h00);

        // 5: interrupt status bit, set beats clear
        drive(1'b1, 4'hC, 8'h01); tick();
        drive(1'b1, 4'hA, 8'h00); tick();
        drive(1'b1, 4'hA, 8'h00);
        check("ifr_irq", data_out, 8'h81);
        drive(1'b1, 4'hB, 8'h01); tick();
        drive(1'b1, 4'hA, 8'h00);
        check("ifr_clr2", data_out, 8'h00);
        tick();
        drive(1'b1, 4'hA, 8'h00); tick();
        drive(1'b1, 4'hB, 8'h01); tick();
        drive(1'b1, 4'hA, 8'h00);
        check("ifr_set_wins", data_out, 8'h81);
        drive(1'b1, 4'h8, 8'h00);
        check("t1_reload2", data_out, 8'h03);
        tick();

        // 6: reset mid-operation
        drive(1'b1, 4'h3, 8'hFF); tick();
        drive(1'b1, 4'h5, 8'h3C); tick();
        check("pa_out", port_a_out, 8'h3C);
        reset = 1'b1;
        drive(1'b1, 4'h5, 8'hFF);
        tick();
        reset = 1'b0;
        check("rst_mid_pa", port_a_out, 8'h00);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 4'h8, 8'h00);
            check("stop_cnt", data_out, 8'h00);
            drive(1'b1, 4'hA, 8'h00);
            check("stop_ifr", data_out, 8'h00);
            tick();
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [3:0] sel;
            logic [7:0] din;
            sel = 4'($urandom_range(0, 15));
            din = 8'($urandom);
            if (sel == 4'h7 || sel == 4'h6) din = din & 8'h07;
            port_a_in = 8'($urandom);
            port_b_in = 8'($urandom);
            reset = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 3) != 0, sel, din);
            tick();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
